// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams program bytes into instruction memory words
//
// Purpose: receives a byte stream, packs every four bytes little-endian into a
// 32-bit word and writes it to the instruction memory at consecutive word
// addresses starting at BASE_ADDR. The CPU core is held in reset until the
// complete image has been loaded.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, len        begin a load of len words (sampled only while idle)
//   s_valid, s_data   byte stream input; s_ready accepts a byte on clk rise
//   mem_we, mem_addr, mem_wdata   instruction memory write port
//   busy              a load is in progress
//   done              one-cycle pulse when the load has finished
//   cpu_rst           core reset, released the cycle after done

module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        cpu_rst
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_len;
  logic [1:0]  r_byte_cnt;
  logic [15:0] r_word_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_s_ready;
  logic        r_mem_we;
  logic        r_busy;
  logic        r_done;
  logic        r_loaded;

  logic [15:0] w_word_cnt_inc;

  assign w_word_cnt_inc = r_word_cnt + 16'd1;

  // r_addr doubles as the registered write address: it holds the current
  // word's address throughout RECV/WRITE and advances as WRITE retires.
  assign s_ready   = r_s_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cpu_rst   = ~r_loaded;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_word_cnt <= 16'd0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= 32'd0;
      r_s_ready  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_loaded   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_loaded   <= 1'b0;
            r_busy     <= 1'b1;
            r_len      <= len;
            r_addr     <= BASE_ADDR;
            r_byte_cnt <= 2'd0;
            r_word_cnt <= 16'd0;
            if (len != 16'd0) begin
              r_state   <= RECV;
              r_s_ready <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end

        RECV: begin
          // Stalls here for as long as the source withholds s_valid.
          if (s_valid) begin
            case (r_byte_cnt)
              2'd0:    r_wdata[7:0]   <= s_data;
              2'd1:    r_wdata[15:8]  <= s_data;
              2'd2:    r_wdata[23:16] <= s_data;
              default: r_wdata[31:24] <= s_data;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state   <= WRITE;
              r_s_ready <= 1'b0;
              r_mem_we  <= 1'b1;
            end
          end
        end

        WRITE: begin
          r_mem_we   <= 1'b0;
          r_addr     <= r_addr + 32'd4;
          r_word_cnt <= w_word_cnt_inc;
          if (w_word_cnt_inc == r_len) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= RECV;
            r_s_ready <= 1'b1;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_loaded <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader

module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        s_valid;
  logic [7:0]  s_data;

  logic        s_ready0, mem_we0, busy0, done0, cpu_rst0;
  logic [31:0] mem_addr0, mem_wdata0;
  logic        s_ready1, mem_we1, busy1, done1, cpu_rst1;
  logic [31:0] mem_addr1, mem_wdata1;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt0 = 0;
  int we_cnt1 = 0;
  int we_mark;

  logic [7:0]  prog [8]     = '{8'hB3, 8'h81, 8'h40, 8'h00, 8'hB3, 8'h81, 8'h11, 8'h40};
  logic [31:0] exp_word [2] = '{32'h004081B3, 32'h401181B3};
  int          gaps [8]     = '{1, 3, 2, 1, 2, 3, 1, 2};

  always #5 clk = ~clk;

  instr_loader #(.BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready0),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .busy(busy0), .done(done0), .cpu_rst(cpu_rst0)
  );

  instr_loader #(.BASE_ADDR(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .busy(busy1), .done(done1), .cpu_rst(cpu_rst1)
  );

  always @(negedge clk) begin
    if (mem_we0) we_cnt0 <= we_cnt0 + 1;
    if (mem_we1) we_cnt1 <= we_cnt1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = 16'hBEEF;
  endtask

  // Drive one byte and return at the negedge following its acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap, input int sel);
    int cnt;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    cnt = 0;
    while (((sel == 0) ? s_ready0 : s_ready1) !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20) check("s_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Send nbytes of prog; right after each 4th byte the write must be visible.
  task automatic send_stream(input int nbytes, input int use_gaps, input int sel,
                             input logic [31:0] base, input string tag);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(prog[i], use_gaps ? gaps[i] : 0, sel);
      if (i % 4 == 3) begin
        if (sel == 0) begin
          check({tag, "_we"},   {31'd0, mem_we0}, 32'd1);
          check({tag, "_addr"}, mem_addr0, base + 32'(4 * (i / 4)));
          check({tag, "_data"}, mem_wdata0, exp_word[i / 4]);
        end else begin
          check({tag, "_we"},   {31'd0, mem_we1}, 32'd1);
          check({tag, "_addr"}, mem_addr1, base + 32'(4 * (i / 4)));
          check({tag, "_data"}, mem_wdata1, exp_word[i / 4]);
        end
      end
    end
  endtask

  task automatic check_finish(input string tag);
    @(negedge clk);
    check({tag, "_done"},     {31'd0, done0},    32'd1);
    check({tag, "_cpurst_d"}, {31'd0, cpu_rst0}, 32'd1);
    check({tag, "_we_off"},   {31'd0, mem_we0},  32'd0);
    @(negedge clk);
    check({tag, "_done_off"}, {31'd0, done0},    32'd0);
    check({tag, "_cpurst"},   {31'd0, cpu_rst0}, 32'd0);
    check({tag, "_busy_off"}, {31'd0, busy0},    32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 16'd0; s_valid = 1'b0; s_data = 8'h00;
    do_reset();
    @(negedge clk);
    check("rst_s_ready", {31'd0, s_ready0}, 32'd0);
    check("rst_mem_we",  {31'd0, mem_we0},  32'd0);
    check("rst_busy",    {31'd0, busy0},    32'd0);
    check("rst_done",    {31'd0, done0},    32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst0}, 32'd1);
    check("rst_addr0",   mem_addr0,  32'h0000_0000);
    check("rst_wdata0",  mem_wdata0, 32'h0000_0000);
    check("rst_addr1",   mem_addr1,  32'hFFFF_FFFC);

    // Continuous two-word load.
    we_mark = we_cnt0;
    do_start(16'd2);
    check("cont_busy",   {31'd0, busy0},    32'd1);
    check("cont_cpurst", {31'd0, cpu_rst0}, 32'd1);
    send_stream(8, 0, 0, 32'h0, "cont");
    check_finish("cont");
    check("cont_we_cnt", we_cnt0 - we_mark, 32'd2);

    // Same load with stalls between bytes.
    we_mark = we_cnt0;
    do_start(16'd2);
    send_stream(8, 1, 0, 32'h0, "gap");
    check_finish("gap");
    check("gap_we_cnt", we_cnt0 - we_mark, 32'd2);

    // Zero-length load.
    we_mark = we_cnt0;
    do_start(16'd0);
    check("len0_done",   {31'd0, done0},    32'd1);
    check("len0_cpurst", {31'd0, cpu_rst0}, 32'd1);
    @(negedge clk);
    check("len0_done_off", {31'd0, done0},    32'd0);
    check("len0_cpurst_0", {31'd0, cpu_rst0}, 32'd0);
    check("len0_we_cnt",   we_cnt0 - we_mark, 32'd0);

    // start during RECV is ignored.
    we_mark = we_cnt0;
    do_start(16'd2);
    send_byte(prog[0], 0, 0);
    send_byte(prog[1], 0, 0);
    start = 1'b1; len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i < 8; i++) begin
      send_byte(prog[i], 0, 0);
      if (i == 3) check("ign_w0_data", mem_wdata0, exp_word[0]);
      if (i == 7) check("ign_w1_addr", mem_addr0, 32'h4);
    end
    check_finish("ign");
    check("ign_we_cnt", we_cnt0 - we_mark, 32'd2);

    // Reset after six bytes aborts the load.
    we_mark = we_cnt0;
    do_start(16'd2);
    send_stream(6, 0, 0, 32'h0, "abort");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_s_ready", {31'd0, s_ready0}, 32'd0);
    check("abort_busy",    {31'd0, busy0},    32'd0);
    check("abort_cpu_rst", {31'd0, cpu_rst0}, 32'd1);
    check("abort_addr",    mem_addr0,  32'h0);
    check("abort_wdata",   mem_wdata0, 32'h0);
    repeat (5) @(negedge clk);
    check("abort_we_cnt", we_cnt0 - we_mark, 32'd1);
    check("abort_busy_idle", {31'd0, busy0}, 32'd0);

    // Address wrap from the top of the address space.
    we_mark = we_cnt1;
    do_start(16'd2);
    send_stream(8, 0, 1, 32'hFFFF_FFFC, "wrap");
    @(negedge clk);
    check("wrap_done", {31'd0, done1}, 32'd1);
    @(negedge clk);
    check("wrap_cpurst", {31'd0, cpu_rst1}, 32'd0);
    check("wrap_we_cnt", we_cnt1 - we_mark, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
